// File: rtl/victim_swap_pkg.sv
// Shared types and default sizes for the victim-cache swap sequencer.
// The top module has one optional feature, enabled with VSC_PERF_CNT_EN.
package victim_swap_pkg;

    localparam int LINE_W_DEF     = 128;
    localparam int ADDR_W_DEF     = 28;
    localparam int VC_ENTRIES_DEF = 4;
    localparam int VC_PTR_W       = $clog2(VC_ENTRIES_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_SWAP,
        ST_WB,
        ST_VCWR,
        ST_RD,
        ST_FILL
    } vsc_state_e;

endpackage

// File: rtl/vsc_shadow_tags.sv
// Shadow tag/valid table mirroring the victim cache, which has no valid bits.
// Its pointer follows the victim cache replacement pointer cycle for cycle.
module vsc_shadow_tags
    import victim_swap_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int VC_ENTRIES = VC_ENTRIES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_inv,
    input  logic [ADDR_W-1:0] i_inv_addr,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_match_one,
    output logic              o_match_valid
);

    localparam int PTR_W = (VC_ENTRIES > 1) ? $clog2(VC_ENTRIES) : 1;
    localparam int CNT_W = $clog2(VC_ENTRIES + 1);

    logic [ADDR_W-1:0]     r_addr [VC_ENTRIES];
    logic [VC_ENTRIES-1:0] r_valid;
    logic [PTR_W-1:0]      r_ptr;
    logic [VC_ENTRIES-1:0] w_match;
    logic [CNT_W-1:0]      w_cnt;

    // Address match ignores valid so duplicate stale tags disqualify a hit.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < VC_ENTRIES; i++) begin
            w_match[i] = (r_addr[i] == i_lookup_addr);
            w_cnt      = w_cnt + CNT_W'(w_match[i]);
        end
    end

    assign o_match_one   = (w_cnt == CNT_W'(1));
    assign o_match_valid = |(w_match & r_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < VC_ENTRIES; i++) begin
                r_addr[i] <= '0;
            end
            r_valid <= '0;
            r_ptr   <= '0;
        end else begin
            for (int i = 0; i < VC_ENTRIES; i++) begin
                if (i_inv && (r_addr[i] == i_inv_addr)) r_valid[i] <= 1'b0;
                if (i_wr && (r_addr[i] == i_wr_addr))   r_valid[i] <= 1'b0;
            end
            if (i_wr) begin
                r_addr[r_ptr]  <= i_wr_addr;
                r_valid[r_ptr] <= 1'b1;
            end
            // The last slot wraps on the following cycle whether or not it was written.
            if (r_ptr == PTR_W'(VC_ENTRIES - 1)) begin
                r_ptr <= '0;
            end else if (i_wr) begin
                r_ptr <= r_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/victim_swap_ctrl.sv
// Miss-path sequencer between the L1 dcache, the victim cache and memory.
// Define VSC_PERF_CNT_EN to add saturating hit/miss fill counters.
module victim_swap_ctrl
    import victim_swap_pkg::*;
#(
    parameter int LINE_W     = LINE_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int VC_ENTRIES = VC_ENTRIES_DEF
) (
    input  logic              clk,
    input  logic              rst,
`ifdef VSC_PERF_CNT_EN
    output logic [31:0]       perf_hit_cnt_o,
    output logic [31:0]       perf_miss_cnt_o,
`endif
    input  logic              miss_req_i,
    input  logic [ADDR_W-1:0] miss_addr_i,
    input  logic              evict_valid_i,
    input  logic              evict_dirty_i,
    input  logic [ADDR_W-1:0] evict_addr_i,
    input  logic [LINE_W-1:0] evict_data_i,
    output logic              miss_ack_o,
    output logic              fill_valid_o,
    output logic [ADDR_W-1:0] fill_addr_o,
    output logic [LINE_W-1:0] fill_data_o,
    output logic              fill_from_vc_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] vc_lookup_addr_o,
    input  logic              vc_hit_i,
    input  logic [LINE_W-1:0] vc_data_i,
    output logic              vc_write_o,
    output logic [ADDR_W-1:0] vc_wr_addr_o,
    output logic [LINE_W-1:0] vc_wr_data_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_rdata_i
);

    vsc_state_e        r_state;
    vsc_state_e        w_next;
    logic [ADDR_W-1:0] r_miss_addr;
    logic              r_ev_valid;
    logic              r_ev_dirty;
    logic [ADDR_W-1:0] r_ev_addr;
    logic [LINE_W-1:0] r_ev_data;
    logic [LINE_W-1:0] r_fill_data;
    logic              r_hit;
    logic              w_ev_eff;
    logic              w_wb_need;
    logic              w_match_one;
    logic              w_match_valid;
    logic              w_qual_hit;
    logic              w_inv;

    // A victim equal to the missing line is the line itself: nothing to store.
    assign w_ev_eff   = r_ev_valid && (r_ev_addr != r_miss_addr);
    assign w_wb_need  = w_ev_eff && r_ev_dirty;
    assign w_qual_hit = vc_hit_i && w_match_one && w_match_valid;

    vsc_shadow_tags #(
        .ADDR_W     (ADDR_W),
        .VC_ENTRIES (VC_ENTRIES)
    ) u_shadow (
        .clk           (clk),
        .rst           (rst),
        .i_wr          (vc_write_o),
        .i_wr_addr     (r_ev_addr),
        .i_inv         (w_inv),
        .i_inv_addr    (r_miss_addr),
        .i_lookup_addr (r_miss_addr),
        .o_match_one   (w_match_one),
        .o_match_valid (w_match_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_miss_addr <= '0;
            r_ev_valid  <= 1'b0;
            r_ev_dirty  <= 1'b0;
            r_ev_addr   <= '0;
            r_ev_data   <= '0;
            r_fill_data <= '0;
            r_hit       <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && miss_req_i) begin
                r_miss_addr <= miss_addr_i;
                r_ev_valid  <= evict_valid_i;
                r_ev_dirty  <= evict_dirty_i;
                r_ev_addr   <= evict_addr_i;
                r_ev_data   <= evict_data_i;
                r_hit       <= 1'b0;
            end
            if (r_state == ST_LOOKUP && w_qual_hit) begin
                r_fill_data <= vc_data_i;
                r_hit       <= 1'b1;
            end
            if (r_state == ST_RD && mem_ack_i) r_fill_data <= mem_rdata_i;
        end
    end

    always_comb begin
        w_next         = r_state;
        miss_ack_o     = 1'b0;
        fill_valid_o   = 1'b0;
        fill_from_vc_o = 1'b0;
        vc_write_o     = 1'b0;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        w_inv          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (miss_req_i) begin
                    miss_ack_o = 1'b1;
                    w_next     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_qual_hit)     w_next = ST_SWAP;
                else if (w_wb_need) w_next = ST_WB;
                else                w_next = ST_VCWR;
            end
            ST_SWAP: begin
                w_inv      = 1'b1;
                vc_write_o = w_ev_eff;
                w_next     = w_wb_need ? ST_WB : ST_FILL;
            end
            ST_WB: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = r_ev_addr;
                mem_wdata_o = r_ev_data;
                if (mem_ack_i) w_next = r_hit ? ST_FILL : ST_VCWR;
            end
            ST_VCWR: begin
                vc_write_o = w_ev_eff;
                w_next     = ST_RD;
            end
            ST_RD: begin
                mem_req_o  = 1'b1;
                mem_addr_o = r_miss_addr;
                if (mem_ack_i) w_next = ST_FILL;
            end
            ST_FILL: begin
                fill_valid_o   = 1'b1;
                fill_from_vc_o = r_hit;
                w_next         = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign busy_o           = (r_state != ST_IDLE);
    assign fill_addr_o      = r_miss_addr;
    assign fill_data_o      = r_fill_data;
    assign vc_lookup_addr_o = r_miss_addr;
    assign vc_wr_addr_o     = r_ev_addr;
    assign vc_wr_data_o     = r_ev_data;

`ifdef VSC_PERF_CNT_EN
    logic [31:0] r_perf_hit;
    logic [31:0] r_perf_miss;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_hit  <= '0;
            r_perf_miss <= '0;
        end else if (r_state == ST_FILL) begin
            if (r_hit && !(&r_perf_hit))    r_perf_hit  <= r_perf_hit + 32'd1;
            if (!r_hit && !(&r_perf_miss))  r_perf_miss <= r_perf_miss + 32'd1;
        end
    end

    assign perf_hit_cnt_o  = r_perf_hit;
    assign perf_miss_cnt_o = r_perf_miss;
`endif

endmodule

// File: tb/tb_victim_swap_ctrl.sv
// Bench for victim_swap_ctrl: victim cache and memory models plus a scoreboard
// of expected fills, victim cache writes and memory operations.
module tb_victim_swap_ctrl;

    localparam int LW = 128;
    localparam int AW = 28;
    localparam int NE = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          miss_req_i = 1'b0;
    logic [AW-1:0] miss_addr_i = '0;
    logic          evict_valid_i = 1'b0;
    logic          evict_dirty_i = 1'b0;
    logic [AW-1:0] evict_addr_i = '0;
    logic [LW-1:0] evict_data_i = '0;
    logic          miss_ack_o, fill_valid_o, fill_from_vc_o, busy_o;
    logic [AW-1:0] fill_addr_o, vc_lookup_addr_o, vc_wr_addr_o, mem_addr_o;
    logic [LW-1:0] fill_data_o, vc_wr_data_o, mem_wdata_o;
    logic          vc_hit_i;
    logic [LW-1:0] vc_data_i;
    logic          vc_write_o, mem_req_o, mem_we_o;
    logic          mem_ack_i = 1'b0;
    logic [LW-1:0] mem_rdata_i = '0;
`ifdef VSC_PERF_CNT_EN
    logic [31:0]   perf_hit_cnt_o, perf_miss_cnt_o;
`endif

    // Victim cache model (no valid bits in hardware; vc_v is the line-residency view).
    logic [AW-1:0] vc_a [NE];
    logic [LW-1:0] vc_d [NE];
    logic          vc_v [NE];
    int            vc_ptr = 0;
    logic [LW-1:0] mem_m [logic [AW-1:0]];
    logic          hit_suppress = 1'b0;
    logic          mem_stall = 1'b0;

    logic [AW+LW-1:0] exp_vc_q [$];
    logic [AW+LW:0]   exp_mem_q [$];
    logic [AW+LW:0]   exp_fill_q [$];
    int               exp_lat_q [$];

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            ack_cyc = 0;
    int            mem_lat = 0;
    logic          req_pend = 1'b0;
    logic [AW:0]   held_op = '0;

    always #5 clk = ~clk;

    victim_swap_ctrl dut (
        .clk              (clk),
        .rst              (rst),
`ifdef VSC_PERF_CNT_EN
        .perf_hit_cnt_o   (perf_hit_cnt_o),
        .perf_miss_cnt_o  (perf_miss_cnt_o),
`endif
        .miss_req_i       (miss_req_i),
        .miss_addr_i      (miss_addr_i),
        .evict_valid_i    (evict_valid_i),
        .evict_dirty_i    (evict_dirty_i),
        .evict_addr_i     (evict_addr_i),
        .evict_data_i     (evict_data_i),
        .miss_ack_o       (miss_ack_o),
        .fill_valid_o     (fill_valid_o),
        .fill_addr_o      (fill_addr_o),
        .fill_data_o      (fill_data_o),
        .fill_from_vc_o   (fill_from_vc_o),
        .busy_o           (busy_o),
        .vc_lookup_addr_o (vc_lookup_addr_o),
        .vc_hit_i         (vc_hit_i),
        .vc_data_i        (vc_data_i),
        .vc_write_o       (vc_write_o),
        .vc_wr_addr_o     (vc_wr_addr_o),
        .vc_wr_data_o     (vc_wr_data_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_ack_i        (mem_ack_i),
        .mem_rdata_i      (mem_rdata_i)
    );

    function automatic logic [LW-1:0] mem_rd(input logic [AW-1:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {4{32'hC0DE_0000 ^ 32'(a)}};
    endfunction

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Raw victim cache compare: any address match hits, lowest slot supplies data.
    always_comb begin
        vc_hit_i  = 1'b0;
        vc_data_i = '0;
        for (int i = NE - 1; i >= 0; i--) begin
            if (vc_a[i] == vc_lookup_addr_o) begin
                vc_hit_i  = !hit_suppress;
                vc_data_i = vc_d[i];
            end
        end
    end

    // Monitor, victim cache write port and memory responder.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            vc_ptr    = 0;
            mem_ack_i = 1'b0;
            mem_lat   = $urandom_range(0, 5);
            req_pend  = 1'b0;
        end else begin
            if (miss_ack_o) begin
                ack_cyc = cyc;
                chk("ack_when_idle", busy_o, 1'b0);
            end
            if (vc_write_o) begin
                if (exp_vc_q.size() == 0) chk("vc_write_unexpected", {vc_wr_addr_o, vc_wr_data_o}, 0);
                else chk("vc_write", {vc_wr_addr_o, vc_wr_data_o}, exp_vc_q.pop_front());
                for (int i = 0; i < NE; i++) if (vc_a[i] == vc_wr_addr_o) vc_v[i] = 1'b0;
                vc_a[vc_ptr] = vc_wr_addr_o;
                vc_d[vc_ptr] = vc_wr_data_o;
                vc_v[vc_ptr] = 1'b1;
            end
            if (vc_ptr == NE - 1) vc_ptr = 0;
            else if (vc_write_o)  vc_ptr++;
            if (fill_valid_o) begin
                if (exp_fill_q.size() == 0) begin
                    chk("fill_unexpected", {fill_addr_o, fill_data_o, fill_from_vc_o}, 0);
                end else begin
                    int lat;
                    lat = exp_lat_q.pop_front();
                    chk("fill", {fill_addr_o, fill_data_o, fill_from_vc_o}, exp_fill_q.pop_front());
                    if (lat >= 0) chk("hit_latency", cyc - ack_cyc, lat);
                end
            end
            if (req_pend) chk("mem_req_held", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, held_op});
            req_pend = 1'b0;
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
            end else if (mem_req_o && !mem_stall) begin
                if (mem_lat == 0) begin
                    logic [AW+LW:0] act;
                    act = {mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : {LW{1'b0}}};
                    if (exp_mem_q.size() == 0) chk("mem_op_unexpected", act, 0);
                    else chk("mem_op", act, exp_mem_q.pop_front());
                    if (mem_we_o) mem_m[mem_addr_o] = mem_wdata_o;
                    else mem_rdata_i = mem_rd(mem_addr_o);
                    mem_ack_i = 1'b1;
                    mem_lat   = $urandom_range(0, 5);
                end else begin
                    mem_lat--;
                end
            end
            if (mem_req_o && !mem_ack_i) begin
                req_pend = 1'b1;
                held_op  = {mem_we_o, mem_addr_o};
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy_o, 1'b0);
    endtask

    task automatic do_miss(input logic [AW-1:0] ma, input logic ev_v, input logic ev_d,
                           input logic [AW-1:0] ea, input logic supp, input logic spurious);
        logic [LW-1:0] ed;
        int cnt, idx;
        logic hit, eff;
        wait_idle(300);
        ed  = ev_d ? {$urandom(), $urandom(), $urandom(), $urandom()} : mem_rd(ea);
        eff = ev_v && (ea != ma);
        cnt = 0;
        idx = 0;
        for (int i = 0; i < NE; i++) if (vc_a[i] == ma) begin cnt++; idx = i; end
        hit = !supp && (cnt == 1) && vc_v[idx];
        if (eff) exp_vc_q.push_back({ea, ed});
        if (eff && ev_d) exp_mem_q.push_back({1'b1, ea, ed});
        if (!hit) exp_mem_q.push_back({1'b0, ma, {LW{1'b0}}});
        exp_fill_q.push_back({ma, mem_rd(ma), hit});
        exp_lat_q.push_back((hit && !(eff && ev_d)) ? 3 : -1);
        if (hit) for (int i = 0; i < NE; i++) if (vc_a[i] == ma) vc_v[i] = 1'b0;
        hit_suppress = supp;
        @(posedge clk); #2;
        miss_req_i    = 1'b1;
        miss_addr_i   = ma;
        evict_valid_i = ev_v;
        evict_dirty_i = ev_d;
        evict_addr_i  = ea;
        evict_data_i  = ed;
        @(negedge clk);
        chk("miss_ack", miss_ack_o, 1'b1);
        @(posedge clk); #2;
        evict_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (spurious) begin
            miss_addr_i = ma ^ 28'h1;
            @(negedge clk);
            chk("ack_while_busy", miss_ack_o, 1'b0);
            @(posedge clk); #2;
        end
        miss_req_i = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            vc_a[i] = '0;
            vc_d[i] = '0;
            vc_v[i] = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobes", {miss_ack_o, fill_valid_o, vc_write_o, mem_req_o, mem_we_o, busy_o, fill_from_vc_o}, 0);
        chk("reset_data", |{fill_addr_o, fill_data_o, vc_lookup_addr_o, vc_wr_addr_o, vc_wr_data_o, mem_addr_o, mem_wdata_o}, 0);
        @(negedge clk);
        rst = 1'b1;

        do_miss(28'h00, 1'b0, 1'b0, 28'h00, 1'b0, 1'b0);
        do_miss(28'h50, 1'b1, 1'b0, 28'h10, 1'b0, 1'b1);
        do_miss(28'h10, 1'b1, 1'b0, 28'h20, 1'b0, 1'b0);
        do_miss(28'h20, 1'b1, 1'b1, 28'h30, 1'b0, 1'b0);
        do_miss(28'h60, 1'b1, 1'b1, 28'h40, 1'b0, 1'b1);
        do_miss(28'h30, 1'b1, 1'b1, 28'h30, 1'b0, 1'b0);
        do_miss(28'h50, 1'b1, 1'b0, 28'h70, 1'b0, 1'b0);
        do_miss(28'h50, 1'b1, 1'b0, 28'h70, 1'b0, 1'b0);
        do_miss(28'h70, 1'b0, 1'b0, 28'h00, 1'b0, 1'b0);

        for (int t = 0; t < 150; t++) begin
            do_miss(AW'(16 * $urandom_range(0, 7)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    AW'(16 * $urandom_range(0, 7)), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Abort a memory read with reset while the request is outstanding.
        wait_idle(300);
        mem_stall    = 1'b1;
        hit_suppress = 1'b1;
        @(posedge clk); #2;
        miss_req_i    = 1'b1;
        miss_addr_i   = 28'h70;
        evict_valid_i = 1'b0;
        @(posedge clk); #2;
        miss_req_i = 1'b0;
        for (int n = 0; n < 20 && !mem_req_o; n++) @(negedge clk);
        chk("rd_before_reset", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b0, 28'h70});
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("abort_strobes", {miss_ack_o, fill_valid_o, vc_write_o, mem_req_o, mem_we_o, busy_o, fill_from_vc_o}, 0);
        chk("abort_data", |{fill_addr_o, fill_data_o, vc_lookup_addr_o, vc_wr_addr_o, vc_wr_data_o, mem_addr_o, mem_wdata_o}, 0);
        model_reset();
        exp_vc_q.delete();
        exp_mem_q.delete();
        exp_fill_q.delete();
        exp_lat_q.delete();
        mem_stall    = 1'b0;
        hit_suppress = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;

        do_miss(28'h00, 1'b1, 1'b0, 28'h10, 1'b0, 1'b0);
        do_miss(28'h10, 1'b0, 1'b0, 28'h00, 1'b0, 1'b0);
        wait_idle(300);
        repeat (4) @(negedge clk);

        chk("vc_q_empty", exp_vc_q.size(), 0);
        chk("mem_q_empty", exp_mem_q.size(), 0);
        chk("fill_q_empty", exp_fill_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
